// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It drives the stage load enables,
// the NOP injection controls and the PC redirect, and keeps the stall and flush counters.
//
// state | meaning
// INIT  | forced NOP injection after reset, PC held
// RUN   | normal hazard arbitration
// DRAIN | mispredict seen without fetch response; waiting to redirect
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        icache_resp_i,
  input  logic        dcache_busy_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [4:0]  ex_rs1_i,
  input  logic [4:0]  ex_rs2_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_mispredict_i,
  input  logic [31:0] ex_target_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        wb_regwrite_i,
  output logic        load_pc_o,
  output logic        load_if_id_o,
  output logic        load_id_ex_o,
  output logic        load_ex_mem_o,
  output logic        load_mem_wb_o,
  output logic        flush_if_id_o,
  output logic        bubble_id_ex_o,
  output logic        overwrite_id_ex_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_redirect_target_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  localparam int CW = (INIT_CYCLES > 3) ? $clog2(INIT_CYCLES) : 2;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] init_cnt_q, init_cnt_d;
  logic [31:0]   target_q, target_d;
  logic [31:0]   stall_q, flush_q;
  logic          stall_inc, flush_inc;
  logic          load_use;

  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    state_d              = state_q;
    init_cnt_d           = init_cnt_q;
    target_d             = target_q;
    stall_inc            = 1'b0;
    flush_inc            = 1'b0;
    load_pc_o            = 1'b0;
    load_if_id_o         = 1'b0;
    load_id_ex_o         = 1'b0;
    load_ex_mem_o        = 1'b0;
    load_mem_wb_o        = 1'b0;
    flush_if_id_o        = 1'b0;
    bubble_id_ex_o       = 1'b0;
    overwrite_id_ex_o    = 1'b0;
    pc_redirect_o        = 1'b0;
    pc_redirect_target_o = 32'd0;

    case (state_q)
      INIT: begin
        load_if_id_o   = 1'b1;
        load_id_ex_o   = 1'b1;
        load_ex_mem_o  = 1'b1;
        load_mem_wb_o  = 1'b1;
        flush_if_id_o  = 1'b1;
        bubble_id_ex_o = 1'b1;
        if (init_cnt_q == '0) state_d = RUN;
        else init_cnt_d = init_cnt_q - CW'(1);
      end

      RUN: begin
        if (dcache_busy_i) begin
          stall_inc = 1'b1;
        end else if (ex_mispredict_i && icache_resp_i) begin
          load_pc_o            = 1'b1;
          load_if_id_o         = 1'b1;
          load_id_ex_o         = 1'b1;
          load_ex_mem_o        = 1'b1;
          load_mem_wb_o        = 1'b1;
          flush_if_id_o        = 1'b1;
          bubble_id_ex_o       = 1'b1;
          pc_redirect_o        = 1'b1;
          pc_redirect_target_o = ex_target_i;
          flush_inc            = 1'b1;
        end else if (ex_mispredict_i) begin
          // Redirect must wait for the outstanding fetch; keep the target for DRAIN.
          target_d       = ex_target_i;
          load_id_ex_o   = 1'b1;
          load_ex_mem_o  = 1'b1;
          load_mem_wb_o  = 1'b1;
          bubble_id_ex_o = 1'b1;
          state_d        = DRAIN;
        end else if (load_use) begin
          load_id_ex_o   = 1'b1;
          load_ex_mem_o  = 1'b1;
          load_mem_wb_o  = 1'b1;
          bubble_id_ex_o = 1'b1;
          stall_inc      = 1'b1;
        end else if (!icache_resp_i) begin
          load_if_id_o  = 1'b1;
          load_id_ex_o  = 1'b1;
          load_ex_mem_o = 1'b1;
          load_mem_wb_o = 1'b1;
          flush_if_id_o = 1'b1;
          stall_inc     = 1'b1;
        end else begin
          load_pc_o     = 1'b1;
          load_if_id_o  = 1'b1;
          load_id_ex_o  = 1'b1;
          load_ex_mem_o = 1'b1;
          load_mem_wb_o = 1'b1;
        end
      end

      DRAIN: begin
        if (dcache_busy_i) begin
          stall_inc = 1'b1;
        end else if (!icache_resp_i) begin
          load_id_ex_o   = 1'b1;
          load_ex_mem_o  = 1'b1;
          load_mem_wb_o  = 1'b1;
          bubble_id_ex_o = 1'b1;
          stall_inc      = 1'b1;
        end else begin
          load_pc_o            = 1'b1;
          load_if_id_o         = 1'b1;
          load_id_ex_o         = 1'b1;
          load_ex_mem_o        = 1'b1;
          load_mem_wb_o        = 1'b1;
          flush_if_id_o        = 1'b1;
          bubble_id_ex_o       = 1'b1;
          pc_redirect_o        = 1'b1;
          pc_redirect_target_o = target_q;
          flush_inc            = 1'b1;
          state_d              = RUN;
        end
      end

      default: state_d = INIT;
    endcase

    // A held ID/EX would otherwise miss the value being written back this cycle.
    if ((state_q != INIT) && !load_id_ex_o && wb_regwrite_i && (wb_rd_i != 5'd0) &&
        ((wb_rd_i == ex_rs1_i) || (wb_rd_i == ex_rs2_i)))
      overwrite_id_ex_o = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= INIT;
      init_cnt_q <= CW'(INIT_CYCLES - 1);
      target_q   <= 32'd0;
      stall_q    <= 32'd0;
      flush_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      target_q   <= target_d;
      if (stall_inc) stall_q <= stall_q + 32'd1;
      if (flush_inc) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_count_o  = flush_q;

endmodule
